// File: rtl/reg_file_8x16.sv
// reg_file_8x16: 8-entry register file with two combinational read ports, one write port,
// per-register "written since reset" tracking and a registered write/read hazard flag.
// Optional `RF_BYPASS_EN` forwards writeData onto a read port that selects the register being written.
module reg_file_8x16 #(
    parameter int unsigned           WIDTH     = 16,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       read1RegSel,
    input  logic [2:0]       read2RegSel,
    input  logic [2:0]       writeRegSel,
    input  logic [WIDTH-1:0] writeData,
    input  logic             write,
    output logic [WIDTH-1:0] read1Data,
    output logic [WIDTH-1:0] read2Data,
    output logic [7:0]       written,
    output logic             err
);

    logic [7:0]       wl;
    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] regs_d [8];
    logic [7:0]       written_q;
    logic [7:0]       written_d;
    logic             err_q;
    logic             err_d;
    logic             read_hit;

    // One-hot word lines: exactly one bit set on a write cycle, none otherwise.
    always_comb begin
        wl = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            wl[i] = write && (writeRegSel == 3'(i));
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            regs_d[i] = wl[i] ? writeData : regs_q[i];
        end
    end

    assign read_hit = (read1RegSel == writeRegSel) || (read2RegSel == writeRegSel);

    // Hazard uses the pre-edge written state, so a first write to a register never flags.
    always_comb begin
        written_d = written_q | wl;
        err_d     = write && written_q[writeRegSel] && read_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            written_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            written_q <= written_d;
            err_q     <= err_d;
        end
    end

`ifdef RF_BYPASS_EN
    // Forwarding is suppressed during reset so the ports still show RESET_VAL.
    always_comb begin
        read1Data = regs_q[read1RegSel];
        read2Data = regs_q[read2RegSel];
        if (rst && write && (read1RegSel == writeRegSel)) begin
            read1Data = writeData;
        end
        if (rst && write && (read2RegSel == writeRegSel)) begin
            read2Data = writeData;
        end
    end
`else
    always_comb begin
        read1Data = regs_q[read1RegSel];
        read2Data = regs_q[read2RegSel];
    end
`endif

    assign written = written_q;
    assign err     = err_q;

endmodule

// File: tb/tb_reg_file_8x16.sv
// Self-checking bench for reg_file_8x16: per-cycle comparison against an array-based model,
// plus directed literal expectations from the test plan.
module tb_reg_file_8x16;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  read1RegSel = '0;
    logic [2:0]  read2RegSel = '0;
    logic [2:0]  writeRegSel = '0;
    logic [15:0] writeData   = '0;
    logic        write       = 1'b0;
    logic [15:0] read1Data;
    logic [15:0] read2Data;
    logic [7:0]  written;
    logic        err;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    reg_file_8x16 #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
        .writeRegSel(writeRegSel), .writeData(writeData), .write(write),
        .read1Data(read1Data), .read2Data(read2Data),
        .written(written), .err(err)
    );

    always #5 clk = ~clk;

    // Model: plain array of register values, written bitmap and hazard flag.
    logic [15:0] m_regs [8];
    logic [7:0]  m_written;
    logic        m_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
            m_written = 8'h00;
            m_err     = 1'b0;
        end else begin
            m_err = write && m_written[writeRegSel] &&
                    (read1RegSel == writeRegSel || read2RegSel == writeRegSel);
            if (write) begin
                m_regs[writeRegSel]    = writeData;
                m_written[writeRegSel] = 1'b1;
            end
        end
    end

    function automatic logic [15:0] m_read(input logic [2:0] sel);
        if (BYP && rst && write && sel == writeRegSel) return writeData;
        return m_regs[sel];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_read1", 32'(read1Data), 32'(m_read(read1RegSel)));
            check("cyc_read2", 32'(read2Data), 32'(m_read(read2RegSel)));
            check("cyc_written", 32'(written), 32'(m_written));
            check("cyc_err", 32'(err), 32'(m_err));
        end
    end

    task automatic drive(input logic w, input logic [2:0] ws, input logic [15:0] wd,
                         input logic [2:0] r1, input logic [2:0] r2);
        write = w; writeRegSel = ws; writeData = wd; read1RegSel = r1; read2RegSel = r2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        tick; tick;
        cmp_en = 1'b1;
        check("rst_written", 32'(written), 32'h00);
        check("rst_err", 32'(err), 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i));
            #1;
            check("rst_read1", 32'(read1Data), 32'h0000);
            check("rst_read2", 32'(read2Data), 32'h0000);
            tick;
        end

        // Fill every register with 1111*(i+1)
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 16'(16'h1111 * (i + 1)), 3'(i), 3'(i));
            tick;
        end
        drive(1'b0, 3'd0, 16'h0000, 3'd5, 3'd7);
        #1;
        check("fill_reg5", 32'(read1Data), 32'h6666);
        check("fill_reg7", 32'(read2Data), 32'h8888);
        check("fill_written", 32'(written), 32'hFF);
        check("fill_err", 32'(err), 32'h0);
        tick;

        // Same-cycle write/read of reg 3
        drive(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd0);
        #1;
        check("beef_same_cycle", 32'(read1Data), BYP ? 32'hBEEF : 32'h4444);
        check("beef_port2_unaffected", 32'(read2Data), 32'h1111);
        tick;
        drive(1'b0, 3'd0, 16'h0000, 3'd3, 3'd0);
        #1;
        check("beef_next_cycle", 32'(read1Data), 32'hBEEF);
        check("beef_err", 32'(err), 32'h1);
        tick;

        // Idle with junk data: nothing changes
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'(i * 2), 16'hFFFF, 3'd1, 3'd6);
            tick;
        end
        check("hold_reg1", 32'(read1Data), 32'h2222);
        check("hold_reg6", 32'(read2Data), 32'h7777);
        check("hold_written", 32'(written), 32'hFF);
        check("hold_err", 32'(err), 32'h0);

        // Mid-cycle reset with an in-flight write held across an edge
        drive(1'b1, 3'd4, 16'h1234, 3'd4, 3'd4);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_read1", 32'(read1Data), 32'h0000);
        check("mid_rst_read2", 32'(read2Data), 32'h0000);
        check("mid_rst_written", 32'(written), 32'h00);
        tick;
        check("rst_discard_read", 32'(read1Data), 32'h0000);
        rst = 1'b1;
        drive(1'b1, 3'd4, 16'hCAFE, 3'd0, 3'd5);
        tick;
        drive(1'b0, 3'd0, 16'h0000, 3'd4, 3'd4);
        #1;
        check("post_rst_write", 32'(read1Data), 32'hCAFE);
        check("post_rst_written", 32'(written), 32'h10);
        tick;

        // Hazard flag on reg 2
        drive(1'b1, 3'd2, 16'hAAAA, 3'd0, 3'd2);
        tick;
        check("haz_first_err", 32'(err), 32'h0);
        check("haz_first_data", 32'(read2Data), BYP ? 32'hAAAA : 32'hAAAA);
        drive(1'b1, 3'd2, 16'hBBBB, 3'd0, 3'd2);
        tick;
        check("haz_second_err", 32'(err), 32'h1);
        drive(1'b0, 3'd0, 16'h0000, 3'd2, 3'd2);
        #1;
        check("haz_second_data", 32'(read2Data), 32'hBBBB);
        check("same_reg_both_ports", 32'(read1Data), 32'hBBBB);
        tick;
        check("haz_clear_err", 32'(err), 32'h0);
        check("final_written", 32'(written), 32'h14);
        tick;

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
